mcp42xxx_chain_driver: RTL and testbench

// SPI master for one or more daisy-chained MCP41xxx/MCP42xxx digital potentiometers (SPI mode 0,0).

---
 rtl/mcp42xxx_chain_driver.sv | 168 ++++++++++++++++
 tb/tb_mcp42xxx_chain_driver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp42xxx_chain_driver.sv
// SPI mode-0 master for a daisy chain of MCP41xxx/MCP42xxx digipots.
// Each accepted request becomes one full-chain frame sent under a single CS assertion.
module mcp42xxx_chain_driver #(
    parameter int NUM_DEVICES = 1,
    parameter int CLK_DIV     = 2,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int CS_IDLE     = 2,
    localparam int DEV_W      = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    output logic             ready,
    input  logic [1:0]       cmd,
    input  logic [1:0]       wiper_mask,
    input  logic [DEV_W-1:0] dev_idx,
    input  logic [7:0]       val,
    output logic             done,
    output logic             cs,
    output logic             sck,
    output logic             mosi
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int BITS    = 16 * NUM_DEVICES;
    localparam int BIT_W   = $clog2(BITS + 1);
    localparam int CNT_MAX = max2(max2(CLK_DIV, CS_SETUP), max2(CS_HOLD, CS_IDLE));
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] BITS_LD  = BIT_W'(BITS - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bits_q, bits_d;
    logic [BITS-1:0]   shreg_q, shreg_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              cs_q, cs_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [BITS-1:0]   frame;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        cs_d    = cs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;

        // Device 0 sits nearest MOSI, so its word occupies the LSBs and is shifted out last.
        frame = '0;
        for (int d = 0; d < NUM_DEVICES; d++) begin
            if (dev_idx == DEV_W'(d)) begin
                frame[16*d +: 16] = {2'b00, cmd, 2'b00, wiper_mask, val};
            end
        end

        case (state_q)
            StIdle: begin
                if (ready_q && valid) begin
                    state_d = StSetup;
                    ready_d = 1'b0;
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    mosi_d  = frame[BITS-1];
                    shreg_d = {frame[BITS-2:0], 1'b0};
                    bits_d  = BITS_LD;
                    cnt_d   = SETUP_LD;
                end else begin
                    ready_d = 1'b1;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StShift;
                    sck_d   = 1'b1;
                    cnt_d   = DIV_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!sck_q) begin
                    sck_d = 1'b1;
                    cnt_d = DIV_LD;
                end else if (bits_q == '0) begin
                    // Last bit: no low phase, falling edge goes straight into HOLD.
                    state_d = StHold;
                    sck_d   = 1'b0;
                    cnt_d   = HOLD_LD;
                end else begin
                    sck_d   = 1'b0;
                    mosi_d  = shreg_q[BITS-1];
                    shreg_d = {shreg_q[BITS-2:0], 1'b0};
                    bits_d  = bits_q - 1'b1;
                    cnt_d   = DIV_LD;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = IDLE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign cs    = cs_q;
    assign sck   = sck_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_mcp42xxx_chain_driver.sv
// Bench for mcp42xxx_chain_driver: three instances (defaults, 3-device chain, fastest timing)
// observed by a bus monitor and compared against a word-level frame model.
module tb_mcp42xxx_chain_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [2:0] valid, ready, done, cs, sck, mosi;
    logic [1:0] cmd_s [3];
    logic [1:0] mask_s[3];
    logic [1:0] dev_s [3];
    logic [7:0] val_s [3];

    mcp42xxx_chain_driver u_dut0 (
        .clk(clk), .reset_n(reset_n), .valid(valid[0]), .ready(ready[0]),
        .cmd(cmd_s[0]), .wiper_mask(mask_s[0]), .dev_idx(dev_s[0][0]), .val(val_s[0]),
        .done(done[0]), .cs(cs[0]), .sck(sck[0]), .mosi(mosi[0])
    );

    mcp42xxx_chain_driver #(.NUM_DEVICES(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .valid(valid[1]), .ready(ready[1]),
        .cmd(cmd_s[1]), .wiper_mask(mask_s[1]), .dev_idx(dev_s[1]), .val(val_s[1]),
        .done(done[1]), .cs(cs[1]), .sck(sck[1]), .mosi(mosi[1])
    );

    mcp42xxx_chain_driver #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .valid(valid[2]), .ready(ready[2]),
        .cmd(cmd_s[2]), .wiper_mask(mask_s[2]), .dev_idx(dev_s[2][0]), .val(val_s[2]),
        .done(done[2]), .cs(cs[2]), .sck(sck[2]), .mosi(mosi[2])
    );

    function automatic int nd(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic int tdiv(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic int exp_low(input int k);
        return tdiv(k) + 2 * tdiv(k) * 16 * nd(k) - tdiv(k) + tdiv(k);
    endfunction

    // Reference frame: target word placed at its chain position, everything else NOP.
    function automatic logic [63:0] model(input int k, input logic [1:0] c, input logic [1:0] m,
                                          input logic [1:0] d, input logic [7:0] v);
        logic [63:0] w;
        w = {48'd0, 2'b00, c, 2'b00, m, v};
        if (int'(d) >= nd(k)) return 64'd0;
        return w << (16 * int'(d));
    endfunction

    int          total = 0;
    int          bad   = 0;
    int          frames[3], dones[3], rises[3], low[3], hi[3], viol[3];
    int          last_rises[3], last_low[3], last_hi[3];
    logic [63:0] cap[3], last_frame[3];
    logic [2:0]  pcs = '1, psck = '0, pmosi = '0;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (!cs[k]) begin
                    if (pcs[k]) begin
                        cap[k]     = '0;
                        rises[k]   = 0;
                        low[k]     = 0;
                        last_hi[k] = hi[k];
                    end
                    low[k]++;
                    if (sck[k] && !psck[k]) begin
                        rises[k]++;
                        cap[k] = {cap[k][62:0], mosi[k]};
                    end
                    if (!pcs[k] && (mosi[k] != pmosi[k]) && !(!sck[k] && psck[k])) viol[k]++;
                end else begin
                    if (sck[k]) viol[k]++;
                    if (!pcs[k]) begin
                        frames[k]++;
                        last_frame[k] = cap[k];
                        last_rises[k] = rises[k];
                        last_low[k]   = low[k];
                        hi[k]         = 0;
                    end
                    hi[k]++;
                end
                if (done[k]) dones[k]++;
                pcs[k]   = cs[k];
                psck[k]  = sck[k];
                pmosi[k] = mosi[k];
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (!ready[k] && n < 5000) begin
            step();
            n++;
        end
        if (!ready[k]) chk("ready timeout", {63'd0, ready[k]}, 64'd1);
    endtask

    task automatic wait_frames(input int k, input int target);
        int n = 0;
        while (frames[k] < target && n < 20000) begin
            step();
            n++;
        end
        if (frames[k] < target) chk("frame timeout", 64'(frames[k]), 64'(target));
    endtask

    task automatic send(input int k, input logic [1:0] c, input logic [1:0] m,
                        input logic [1:0] d, input logic [7:0] v);
        wait_ready(k);
        cmd_s[k]  = c;
        mask_s[k] = m;
        dev_s[k]  = d;
        val_s[k]  = v;
        valid[k]  = 1'b1;
        step();
        valid[k] = 1'b0;
        // Garbage while busy must not reach the frame.
        cmd_s[k]  = 2'($urandom);
        mask_s[k] = 2'($urandom);
        dev_s[k]  = 2'($urandom);
        val_s[k]  = 8'($urandom);
    endtask

    task automatic run_frame(input int k, input logic [1:0] c, input logic [1:0] m,
                             input logic [1:0] d, input logic [7:0] v, input logic [63:0] e);
        int f0, d0, n;
        f0 = frames[k];
        d0 = dones[k];
        send(k, c, m, d, v);
        wait_frames(k, f0 + 1);
        n = 0;
        while (!ready[k] && n < 100) begin
            step();
            n++;
        end
        chk($sformatf("frame dut%0d", k), last_frame[k], e);
        chk($sformatf("sck rises dut%0d", k), 64'(last_rises[k]), 64'(16 * nd(k)));
        chk($sformatf("cs low dut%0d", k), 64'(last_low[k]), 64'(exp_low(k)));
        chk($sformatf("done count dut%0d", k), 64'(dones[k] - d0), 64'd1);
        chk($sformatf("idle gap dut%0d", k), 64'(n), 64'(tdiv(k)));
        chk($sformatf("bus rules dut%0d", k), 64'(viol[k]), 64'd0);
    endtask

    typedef struct {
        int          k;
        logic [1:0]  c;
        logic [1:0]  m;
        logic [1:0]  d;
        logic [7:0]  v;
        logic [63:0] e;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int f0, d0, n, k;
        logic [1:0] c, m, d;
        logic [7:0] v;

        tbl[0] = '{0, 2'b01, 2'b01, 2'd0, 8'h2A, 64'h112A};
        tbl[1] = '{1, 2'b01, 2'b11, 2'd1, 8'hFF, 64'h0000_13FF_0000};
        tbl[2] = '{0, 2'b10, 2'b01, 2'd0, 8'h00, 64'h2100};
        tbl[3] = '{0, 2'b00, 2'b01, 2'd0, 8'h00, 64'h0100};
        tbl[4] = '{1, 2'b01, 2'b11, 2'd3, 8'h55, 64'h0};
        tbl[5] = '{2, 2'b01, 2'b01, 2'd0, 8'h2A, 64'h112A};
        tbl[6] = '{1, 2'b11, 2'b10, 2'd0, 8'h80, 64'h3280};
        tbl[7] = '{1, 2'b01, 2'b01, 2'd2, 8'h01, 64'h1101_0000_0000};

        for (int i = 0; i < 3; i++) begin
            frames[i] = 0; dones[i] = 0; rises[i] = 0; low[i] = 0; hi[i] = 0; viol[i] = 0;
            cmd_s[i] = '0; mask_s[i] = '0; dev_s[i] = '0; val_s[i] = '0;
        end
        valid   = '0;
        reset_n = 1'b0;
        repeat (3) step();
        chk("reset cs", 64'(cs), 64'h7);
        chk("reset sck", 64'(sck), 64'h0);
        chk("reset mosi", 64'(mosi), 64'h0);
        chk("reset ready", 64'(ready), 64'h0);
        chk("reset done", 64'(done), 64'h0);
        reset_n = 1'b1;
        step();
        chk("ready after reset", 64'(ready), 64'h7);
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].k, tbl[i].c, tbl[i].m, tbl[i].d, tbl[i].v, tbl[i].e);
        end

        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(0, 2));
            c = 2'($urandom);
            m = 2'($urandom);
            d = 2'($urandom_range(0, (nd(k) == 1) ? 1 : 3));
            v = 8'($urandom);
            run_frame(k, c, m, d, v, model(k, c, m, d, v));
        end

        // Back-to-back: valid held; mid-frame input change is ignored for frame 1.
        wait_ready(0);
        f0 = frames[0];
        d0 = dones[0];
        cmd_s[0] = 2'b01; mask_s[0] = 2'b01; dev_s[0] = 2'd0; val_s[0] = 8'h2A;
        valid[0] = 1'b1;
        repeat (20) step();
        mask_s[0] = 2'b10;
        val_s[0]  = 8'h49;
        wait_frames(0, f0 + 1);
        chk("b2b frame1", last_frame[0], 64'h112A);
        wait_ready(0);
        step();
        valid[0] = 1'b0;
        wait_frames(0, f0 + 2);
        chk("b2b frame2", last_frame[0], 64'h1249);
        chk("b2b cs high gap", 64'(last_hi[0]), 64'd3);
        repeat (150) step();
        chk("b2b frame count", 64'(frames[0] - f0), 64'd2);
        chk("b2b done count", 64'(dones[0] - d0), 64'd2);

        // Reset during bit 5 abandons the frame without done.
        send(0, 2'b01, 2'b01, 2'd0, 8'h2A);
        n = 0;
        while (rises[0] < 5 && n < 1000) begin
            step();
            n++;
        end
        chk("reach bit 5", 64'(rises[0]), 64'd5);
        d0 = dones[0];
        reset_n = 1'b0;
        step();
        chk("midreset cs", {63'd0, cs[0]}, 64'd1);
        chk("midreset sck", {63'd0, sck[0]}, 64'd0);
        chk("midreset mosi", {63'd0, mosi[0]}, 64'd0);
        chk("midreset ready", {63'd0, ready[0]}, 64'd0);
        chk("midreset done", {63'd0, done[0]}, 64'd0);
        reset_n = 1'b1;
        step();
        chk("midreset ready back", {63'd0, ready[0]}, 64'd1);
        repeat (5) step();
        chk("midreset no done", 64'(dones[0]), 64'(d0));
        run_frame(0, 2'b01, 2'b01, 2'd0, 8'h2A, 64'h112A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
